// File: rtl/clk_sched.sv
`default_nettype none
// ============================================================================
// Module      : clk_sched
// Description : Programmable clock-enable scheduler. Issues a one-cycle
//               clk_mask pulse every period_q cycles. Supports halt (with
//               drain of the current period), resume, and single-step.
//               Optional feature macro: CLK_SCHED_MASK_CNT_EN adds a 16-bit
//               count of issued mask pulses on mask_cnt. When it is not
//               defined, mask_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sched #(
   parameter  int MAX_PERIOD = 16,
   parameter  int PERIOD     = 4,
   localparam int W          = $clog2(MAX_PERIOD + 1)
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         cfg_we,
   input  logic [W-1:0] cfg_period,
   input  logic         halt_req,
   input  logic         resume_req,
   input  logic         step_req,
   output logic         clk_mask,
   output logic         halted,
   output logic [W-1:0] period_q,
   output logic [15:0]  mask_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   state_t       r_state;
   logic [W-1:0] r_cnt;
   logic [W-1:0] r_period;
   logic [W-1:0] r_pend;
   logic         r_pend_vld;

   logic [W-1:0] w_clamp;
   logic [W-1:0] w_cnt_next;
   logic         w_counting;
   logic         w_wrap;
   logic         w_apply;

   // cnt only advances in RUN/DRAIN; the last count of a period is the wrap point
   assign w_counting = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_wrap     = (r_cnt == (r_period - W'(1)));
   assign w_cnt_next = w_wrap ? '0 : (r_cnt + W'(1));

   // A pending period takes effect only at a period boundary or while halted,
   // so a running mask interval is never cut short or doubled.
   assign w_apply = r_pend_vld && ((w_counting && w_wrap) || (r_state == ST_HALTED));

   // Clamp the requested period into the legal range 1..MAX_PERIOD
   always_comb begin
      w_clamp = cfg_period;
      if (cfg_period == '0) begin
         w_clamp = W'(1);
      end else if (cfg_period > W'(MAX_PERIOD)) begin
         w_clamp = W'(MAX_PERIOD);
      end
   end

   // Scheduler FSM and period counter; halt_req > resume_req > step_req
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
         r_cnt   <= W'(PERIOD - 1);
      end else begin
         case (r_state)
            ST_RUN: begin
               if (halt_req && w_wrap) begin
                  // Current period already complete: stop without a drain phase
                  r_state <= ST_HALTED;
                  r_cnt   <= '0;
               end else begin
                  if (halt_req) begin
                     r_state <= ST_DRAIN;
                  end
                  r_cnt <= w_cnt_next;
               end
            end
            ST_DRAIN: begin
               if (!halt_req && resume_req) begin
                  r_state <= ST_RUN;
                  r_cnt   <= w_cnt_next;
               end else if (w_wrap) begin
                  r_state <= ST_HALTED;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            ST_HALTED: begin
               r_cnt <= '0;
               if (halt_req) begin
                  r_state <= ST_HALTED;
               end else if (resume_req) begin
                  r_state <= ST_RUN;
               end else if (step_req) begin
                  r_state <= ST_STEP;
               end
            end
            ST_STEP: begin
               r_state <= ST_HALTED;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= ST_RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Active/pending period registers; a new write overrides an unapplied one
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_period   <= W'(PERIOD);
         r_pend     <= W'(PERIOD);
         r_pend_vld <= 1'b0;
      end else begin
         if (w_apply) begin
            r_period   <= r_pend;
            r_pend_vld <= 1'b0;
         end
         if (cfg_we) begin
            r_pend     <= w_clamp;
            r_pend_vld <= 1'b1;
         end
      end
   end

   assign clk_mask = rst & ((w_counting & (r_cnt == '0)) | (r_state == ST_STEP));
   assign halted   = rst & (r_state == ST_HALTED);
   assign period_q = r_period;

`ifdef CLK_SCHED_MASK_CNT_EN
   logic [15:0] r_mask_cnt;

   // Count every issued mask pulse, wrapping at 16 bits
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_mask_cnt <= '0;
      end else if (clk_mask) begin
         r_mask_cnt <= r_mask_cnt + 16'd1;
      end
   end

   assign mask_cnt = r_mask_cnt;
`else
   assign mask_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/clk_sched.md
CLK_SCHED -- requirements
Module: clk_sched

Interface
REQ-001 Parameter MAX_PERIOD, default 16: largest programmable mask period, in clk_in cycles.
REQ-002 Parameter PERIOD, default 4: period loaded at reset.
REQ-003 W = $clog2(MAX_PERIOD+1); this width applies to all period and counter fields.
REQ-004 clk_in  input  1  the single clock; every flop SHALL use the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 cfg_we  input  1  one-cycle strobe that writes cfg_period.
REQ-007 cfg_period  input  W  requested mask period.
REQ-008 halt_req  input  1  level-sampled request to stop issuing masks.
REQ-009 resume_req  input  1  level-sampled request to restart free-running masks.
REQ-010 step_req  input  1  level-sampled request for exactly one mask while halted.
REQ-011 clk_mask  output  1  one-cycle clock-enable pulse for downstream logic.
REQ-012 halted  output  1  high while the FSM is in HALTED.
REQ-013 period_q  output  W  currently active period.
REQ-014 mask_cnt  output  16  count of issued masks; exists only with the Configuration feature.

Function
REQ-015 FSM states SHALL be RUN, DRAIN, HALTED and STEP, with a free-running counter cnt[W-1:0].
REQ-016 In RUN and DRAIN, cnt SHALL count 0..period_q-1 and then wrap to 0.
REQ-017 clk_mask SHALL equal rst & ((state in {RUN, DRAIN} & cnt==0) | state==STEP), with no other term.
REQ-018 A cfg_we write SHALL store the clamped value in a pending register.
REQ-019 Clamp rules: 0 becomes 1; values above MAX_PERIOD become MAX_PERIOD.
REQ-020 A pending period SHALL be applied on the cycle cnt wraps to 0, or immediately while HALTED, so no mask pulse is ever shortened or doubled.
REQ-021 A second cfg_we before the pending period is applied SHALL overwrite the pending value (last write wins).
REQ-022 RUN + halt_req SHALL go to DRAIN; if cnt==period_q-1 on that same cycle, the FSM SHALL go directly to HALTED.
REQ-023 DRAIN SHALL go to HALTED on the cycle cnt==period_q-1, so the current period completes and no further mask is issued.
REQ-024 In HALTED, cnt SHALL be held at 0 and halted SHALL be 1.
REQ-025 HALTED + resume_req SHALL go to RUN with cnt=0, so clk_mask is high in the next cycle.
REQ-026 HALTED + step_req (without resume_req) SHALL go to STEP for exactly one cycle (clk_mask=1), then return to HALTED.
REQ-027 A step_req held high SHALL produce one step every two cycles (STEP, HALTED, STEP, ...).
REQ-028 Priority among simultaneous requests SHALL be halt_req > resume_req > step_req.
REQ-029 step_req in RUN or DRAIN and resume_req in RUN SHALL be ignored.
REQ-030 resume_req in DRAIN SHALL cancel the drain and return to RUN without disturbing cnt.
REQ-031 halt_req in STEP SHALL be honoured by returning to HALTED (the normal STEP exit).
REQ-032 With period_q==1, clk_mask SHALL be high every cycle in RUN.
REQ-033 With period_q==1, halt_req in RUN SHALL reach HALTED on the next edge.

Reset
REQ-034 While rst==0: state=RUN, period_q=PERIOD, pending period=PERIOD with no update flagged, cnt=PERIOD-1, mask_cnt=0.
REQ-035 While rst==0, clk_mask and halted SHALL both be 0.
REQ-036 On the first rising edge after reset release, cnt SHALL wrap to 0, so clk_mask is high in cycle 1.
REQ-037 Reset asserted mid-DRAIN or mid-STEP SHALL abort immediately, with no extra mask pulse.

Configuration
REQ-038 Macro CLK_SCHED_MASK_CNT_EN SHALL control the mask counter feature.
REQ-039 When CLK_SCHED_MASK_CNT_EN is defined, mask_cnt SHALL increment on every cycle clk_mask==1 and wrap 0xFFFF -> 0x0000.
REQ-040 When CLK_SCHED_MASK_CNT_EN is undefined, no counter flops SHALL exist and mask_cnt SHALL be tied to 0.

Verification
REQ-041 Reset release with PERIOD=4, no requests -> clk_mask high in cycles 1, 5, 9, 13; halted=0 throughout.
REQ-042 RUN with period 4, cfg_we with cfg_period=2 at cnt==1 -> next two masks 4 cycles apart, then 2 apart.
REQ-043 RUN with period 4, cfg_we with cfg_period=0 -> period_q=1 after the wrap.
REQ-044 RUN with period 4, cfg_we with cfg_period=MAX_PERIOD+5 -> period_q=MAX_PERIOD.
REQ-045 RUN with period 4, halt_req pulsed at cnt==1 -> no further mask; halted=1 three cycles later; clk_mask stays 0 for 20 cycles.
REQ-046 HALTED, step_req pulse -> exactly one mask pulse, halted drops for one cycle only.
REQ-047 HALTED, step_req held 6 cycles -> 3 mask pulses.
REQ-048 HALTED, step_req and resume_req in the same cycle -> RUN, mask next cycle, then every period_q cycles.
REQ-049 RUN, halt_req and resume_req in the same cycle -> DRAIN then HALTED.
REQ-050 rst pulsed low during DRAIN -> clk_mask=0 during reset; first mask in cycle 1 after release.
REQ-051 With CLK_SCHED_MASK_CNT_EN, mask_cnt equals the number of observed mask pulses; without it, mask_cnt==0 always.
